srl_deser: RTL and testbench
============================

# srl_deser

Serial-to-parallel front end for the bus delay line. Collects a 1-bit stream, bit by bit, into WIDTH-bit words. Each word is presented on a registered parallel output with a valid/ready handshake, so the delay-line stage can take it directly. Supports frame alignment via a start-of-word marker, back-pressure toward the serial source, and a misalignment pulse.

## Interface
Parameters:
- WIDTH, 8, word width in bits; must be ≥ 2

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous reset, active-high
- in  in  1  serial data bit
- in_valid  in  1  `in` carries a bit this cycle
- in_sof  in  1  the accepted bit is bit 0 of a new word; sampled only when a bit is accepted
- in_ready  out  1  block can accept a bit this cycle
- out  out  WIDTH  assembled word, registered
- out_valid  out  1  `out` holds a word not yet consumed
- out_ready  in  1  downstream consumes `out` this cycle
- misalign  out  1  one-cycle pulse: a partial word was discarded by `in_sof`

## Operation
- Internal state:
  - assembly register `sh[WIDTH-1:0]`
  - bit counter `cnt`, width $clog2(WIDTH), range 0..WIDTH-1
  - pending flag `pend`: a complete word is held in `sh` awaiting the output slot
- Bit acceptance: `acc = in_valid & in_ready`. `in_ready = ~pend`, driven from a register only, with no combinational path from `out_ready`.
- On `acc`, the bit index is `idx = in_sof ? 0 : cnt`:
  - LSB-first by default: bit 0 of the word is the first bit received.
  - `sh[idx] <= in`
  - If `idx == WIDTH-1`, the word is complete and `cnt <= 0`; otherwise `cnt <= idx + 1`.
- `in_sof` with `cnt != 0`: the partial word is dropped, `misalign <= 1` for one cycle, and assembly restarts at index 0 with the current bit. `in_sof` with `cnt == 0` has no side effect.
- Output slot is free when `~out_valid | out_ready`.
- Word completion:
  - If the slot is free: `out <= {completed word}` and `out_valid <= 1` on the same edge. The completed word includes the bit being written this cycle.
  - Otherwise: `pend <= 1` and `sh` is frozen.
- While `pend`: when the slot is free, `out <= sh`, `out_valid <= 1` and `pend <= 0`.
- Otherwise, `out_valid & out_ready` clears `out_valid`. `out` keeps its last value.
- WIDTH == 1 is not supported, because the `cnt` width would be 0.

## Timing
- Reset values: `out = 0`, `out_valid = 0`, `in_ready = 1`, `misalign = 0`, `cnt = 0`, `pend = 0`, `sh = 0`.
- Reset has priority over every other input on the same edge. Reset mid-word drops both the partial word and any pending word without raising `misalign`.
- Latency: last bit accepted at edge k → `out_valid = 1` and `out` is valid from edge k onward, i.e. visible in cycle k+1.
- Throughput: one bit per cycle sustained when `out_ready` stays high, i.e. one word every WIDTH cycles, with no bubbles.
- Back-pressure: a completed word finding the slot busy sets `pend`, and `in_ready` goes low from the next cycle. When `out_ready` then frees the slot, `in_ready` returns high one cycle later.
- Buffering: at most two words in flight (`out` plus `sh`). No bit is ever lost or overwritten.
- Simultaneous events:
  - Slot draining (`out_valid & out_ready`) in the same cycle as a word completing: the new word replaces `out`, and `out_valid` stays high.
  - `in_sof` on the last index of a partial word: the sof rule wins, so the index is forced to 0.
- `in`/`in_sof` are don't-care when `acc = 0`.

## Configuration
- `SRL_DESER_MSB_FIRST_EN` defined: the bit index is mirrored to `WIDTH-1-idx`, so the first received bit lands in `out[WIDTH-1]`. Counter, completion and sof behaviour are unchanged.
- Undefined (default): LSB-first, as described above.

## Test plan
- Reset: assert `rst` for 2 cycles mid-word → `out=0`, `out_valid=0`, `in_ready=1`, `misalign=0`. A fresh 8-bit word then completes after exactly 8 accepted bits.
- Streaming, WIDTH=8, `out_ready=1`: send bits of 0xA5 then 0x3C LSB-first, continuous `in_valid` → `out=0xA5` visible the cycle after the 8th bit and `out=0x3C` 8 cycles later, each with `out_valid` high for exactly 1 cycle.
- Back-pressure:
  - Hold `out_ready=0` and send 0x11, 0x22, then a third word → `in_ready` drops after 0x22 completes, and the third word's bits are stalled.
  - Release `out_ready` → 0x11, 0x22 and the third word are delivered in order with no loss.
- Sof realign: send 3 bits, then 8 bits (0x5A) with `in_sof` on the first → `misalign` pulses once and `out=0x5A`. `in_sof` at `cnt=0` → no pulse.
- Completion + drain in the same cycle: `out_valid=1` with `out_ready=1` on the cycle a new word completes → `out_valid` remains 1 and the new value appears next cycle.
- With `SRL_DESER_MSB_FIRST_EN`: serial 1,0,0,0,0,0,0,0 → `out=0x80`; without the macro → `out=0x01`.

Source files
------------

// File: rtl/srl_deser_if.sv
// Handshake bundle for srl_deser: serial bit stream in, parallel words out.
// The slave modport is the deserializer; master is the side that drives it.
interface srl_deser_if #(
    parameter int WIDTH = 8
);
    logic             in;
    logic             in_valid;
    logic             in_sof;
    logic             in_ready;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready;
    logic             misalign;

    modport master (
        output in, in_valid, in_sof, out_ready,
        input  in_ready, out, out_valid, misalign
    );

    modport slave (
        input  in, in_valid, in_sof, out_ready,
        output in_ready, out, out_valid, misalign
    );
endinterface

// File: rtl/srl_deser.sv
// Serial-to-parallel deserializer with sof alignment, back-pressure and a misalign pulse.
// Define SRL_DESER_MSB_FIRST_EN to place the first received bit in out[WIDTH-1].
module srl_deser #(
    parameter int WIDTH = 8
) (
    input logic        clk,
    input logic        rst,
    srl_deser_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             misalign_q, misalign_d;

    logic             acc;
    logic             slot_free;
    logic [CW-1:0]    idx;
    logic [CW-1:0]    widx;
    logic [WIDTH-1:0] word;
    logic             complete;

    always_comb begin
        acc       = bus.in_valid & ~pend_q;
        slot_free = ~out_valid_q | bus.out_ready;
        idx       = bus.in_sof ? '0 : cnt_q;
`ifdef SRL_DESER_MSB_FIRST_EN
        widx      = LAST - idx;
`else
        widx      = idx;
`endif
        // Completed word must include the bit being written on this edge.
        word       = sh_q;
        word[widx] = bus.in;
        complete   = acc & (idx == LAST);

        sh_d        = sh_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        misalign_d  = 1'b0;

        if (pend_q) begin
            // Input is stalled here; only the held word can move.
            if (slot_free) begin
                out_d       = sh_q;
                out_valid_d = 1'b1;
                pend_d      = 1'b0;
            end
        end else if (acc) begin
            sh_d       = word;
            cnt_d      = complete ? '0 : idx + CW'(1);
            misalign_d = bus.in_sof & (cnt_q != '0);
            if (complete) begin
                if (slot_free) begin
                    out_d       = word;
                    out_valid_d = 1'b1;
                end else begin
                    pend_d = 1'b1;
                end
            end else if (out_valid_q & bus.out_ready) begin
                out_valid_d = 1'b0;
            end
        end else if (out_valid_q & bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q        <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            misalign_q  <= misalign_d;
        end
    end

    // in_ready comes straight from a flop so out_ready never reaches the source.
    assign bus.in_ready  = ~pend_q;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.misalign  = misalign_q;
endmodule

// File: tb/tb_srl_deser.sv
// Directed self-checking bench for srl_deser, WIDTH = 8.
// Honors SRL_DESER_MSB_FIRST_EN so the same bench covers both bit orders.
module tb_srl_deser;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    srl_deser_if #(.WIDTH(8)) bus ();

    srl_deser #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Words are sent LSB of the byte first; in MSB-first builds they land bit-reversed.
    function automatic logic [7:0] exp_w(input logic [7:0] v);
        logic [7:0] r;
`ifdef SRL_DESER_MSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[7-i] = v[i];
`else
        r = v;
`endif
        return r;
    endfunction

    task automatic send_word(input logic [7:0] v, input logic sof);
        for (int i = 0; i < 8; i++) begin
            bus.in       = v[i];
            bus.in_valid = 1'b1;
            bus.in_sof   = sof && (i == 0);
            step();
        end
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    initial begin
        logic [15:0] pair;
        logic [7:0]  w;
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        chk("rst_out", 32'(bus.out), 32'h0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
        chk("rst_misalign", 32'(bus.misalign), 32'h0);
        rst = 1'b0;

        // Bit order: serial 1,0,0,0,0,0,0,0
        send_word(8'h01, 1'b0);
`ifdef SRL_DESER_MSB_FIRST_EN
        chk("order_out", 32'(bus.out), 32'h80);
`else
        chk("order_out", 32'(bus.out), 32'h01);
`endif
        chk("order_valid", 32'(bus.out_valid), 32'h1);

        // Continuous streaming of 0xA5 then 0x3C
        pair = 16'h3CA5;
        for (int i = 0; i < 16; i++) begin
            bus.in       = pair[i];
            bus.in_valid = 1'b1;
            step();
            if (i == 7) begin
                chk("stream_a5_valid", 32'(bus.out_valid), 32'h1);
                chk("stream_a5_out", 32'(bus.out), 32'(exp_w(8'hA5)));
            end
            if (i == 8) chk("stream_a5_one_cycle", 32'(bus.out_valid), 32'h0);
            if (i == 15) begin
                chk("stream_3c_valid", 32'(bus.out_valid), 32'h1);
                chk("stream_3c_out", 32'(bus.out), 32'(exp_w(8'h3C)));
            end
        end
        bus.in_valid = 1'b0;
        step();
        chk("stream_3c_one_cycle", 32'(bus.out_valid), 32'h0);

        // Back-pressure
        bus.out_ready = 1'b0;
        send_word(8'h11, 1'b0);
        chk("bp_11_out", 32'(bus.out), 32'(exp_w(8'h11)));
        chk("bp_11_in_ready", 32'(bus.in_ready), 32'h1);
        send_word(8'h22, 1'b0);
        chk("bp_22_in_ready_low", 32'(bus.in_ready), 32'h0);
        w            = 8'h33;
        bus.in       = w[0];
        bus.in_valid = 1'b1;
        repeat (3) step();
        chk("bp_stall_in_ready", 32'(bus.in_ready), 32'h0);
        chk("bp_stall_out", 32'(bus.out), 32'(exp_w(8'h11)));
        chk("bp_stall_valid", 32'(bus.out_valid), 32'h1);
        bus.out_ready = 1'b1;
        step();
        chk("bp_22_out", 32'(bus.out), 32'(exp_w(8'h22)));
        chk("bp_22_valid", 32'(bus.out_valid), 32'h1);
        chk("bp_in_ready_back", 32'(bus.in_ready), 32'h1);
        send_word(8'h33, 1'b0);
        chk("bp_33_out", 32'(bus.out), 32'(exp_w(8'h33)));
        chk("bp_33_valid", 32'(bus.out_valid), 32'h1);
        step();

        // Sof realignment after a 3-bit partial word
        for (int i = 0; i < 3; i++) begin
            bus.in       = 1'b1;
            bus.in_valid = 1'b1;
            step();
        end
        chk("sof_pre_misalign", 32'(bus.misalign), 32'h0);
        w = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            bus.in       = w[i];
            bus.in_valid = 1'b1;
            bus.in_sof   = (i == 0);
            step();
            if (i == 0) chk("sof_misalign_pulse", 32'(bus.misalign), 32'h1);
            if (i == 1) chk("sof_misalign_clear", 32'(bus.misalign), 32'h0);
        end
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        chk("sof_5a_out", 32'(bus.out), 32'(exp_w(8'h5A)));
        chk("sof_5a_valid", 32'(bus.out_valid), 32'h1);
        w = 8'h0F;
        for (int i = 0; i < 8; i++) begin
            bus.in       = w[i];
            bus.in_valid = 1'b1;
            bus.in_sof   = (i == 0);
            step();
            if (i == 0) chk("sof_cnt0_no_pulse", 32'(bus.misalign), 32'h0);
        end
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        chk("sof_0f_out", 32'(bus.out), 32'(exp_w(8'h0F)));
        step();

        // Completion coinciding with drain
        bus.out_ready = 1'b0;
        send_word(8'h44, 1'b0);
        chk("drain_44_out", 32'(bus.out), 32'(exp_w(8'h44)));
        w = 8'h99;
        for (int i = 0; i < 8; i++) begin
            bus.in        = w[i];
            bus.in_valid  = 1'b1;
            bus.out_ready = (i == 7);
            step();
        end
        bus.in_valid = 1'b0;
        chk("drain_99_out", 32'(bus.out), 32'(exp_w(8'h99)));
        chk("drain_99_valid", 32'(bus.out_valid), 32'h1);
        chk("drain_99_in_ready", 32'(bus.in_ready), 32'h1);
        bus.out_ready = 1'b1;
        step();

        // Reset mid-word, then a fresh word takes exactly 8 bits
        for (int i = 0; i < 3; i++) begin
            bus.in       = 1'b1;
            bus.in_valid = 1'b1;
            step();
        end
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("midrst_out", 32'(bus.out), 32'h0);
        chk("midrst_valid", 32'(bus.out_valid), 32'h0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'h1);
        chk("midrst_misalign", 32'(bus.misalign), 32'h0);
        w = 8'hC3;
        for (int i = 0; i < 8; i++) begin
            bus.in       = w[i];
            bus.in_valid = 1'b1;
            step();
            if (i == 6) chk("midrst_7bits_not_done", 32'(bus.out_valid), 32'h0);
        end
        bus.in_valid = 1'b0;
        chk("midrst_c3_valid", 32'(bus.out_valid), 32'h1);
        chk("midrst_c3_out", 32'(bus.out), 32'(exp_w(8'hC3)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
